u712_chipram_sched: RTL and testbench

- Scheduler for the chip RAM SDRAM behind the U712 chip RAM sequencer.
- Runs the SDRAM power-up init: CKE enable, precharge-all, two auto-refreshes, mode register load.
- Issues periodic auto-refresh at a fixed interval.
- Arbitrates the single SDRAM port between Agnus DMA and CPU requests. The chip RAM sequencer executes granted cycles and reports completion.

---
 rtl/u712_pkg.sv | 30 +++
 rtl/u712_refresh_timer.sv | 45 ++++
 rtl/u712_chipram_sched.sv | 140 ++++++++++++++
 tb/tb_u712_chipram_sched.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/u712_pkg.sv
// Shared definitions for the U712 chip RAM scheduler: SDRAM command codes,
// the precharge-all address and the scheduler state encoding.
package u712_pkg;

    localparam logic [1:0] CMD_NOP = 2'b00;
    localparam logic [1:0] CMD_PRE = 2'b01;
    localparam logic [1:0] CMD_REF = 2'b10;
    localparam logic [1:0] CMD_MRS = 2'b11;

    // A10 high selects all banks for PRECHARGE
    localparam logic [10:0] CMA_PRECHARGE_ALL = 11'h400;

    typedef enum logic [3:0] {
        ST_WAIT_PWR,
        ST_WAIT_CKE,
        ST_PRE,
        ST_TRP,
        ST_REF1,
        ST_TRC1,
        ST_REF2,
        ST_TRC2,
        ST_MRS,
        ST_TMRD,
        ST_IDLE,
        ST_RWAIT,
        ST_DMA_BUSY,
        ST_CPU_BUSY
    } sched_state_t;

endpackage

// File: rtl/u712_refresh_timer.sv
// Refresh interval timer with a 3-bit saturating debt of refreshes still owed.
module u712_refresh_timer #(
    parameter int REF_INTERVAL = 624
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic issue,
    output logic tick,
    output logic debt_nz,
    output logic overrun
);

    localparam int CW = $clog2(REF_INTERVAL + 1);
    localparam logic [CW-1:0] LAST = CW'(REF_INTERVAL - 1);

    logic [CW-1:0] interval_cnt;
    logic [2:0]    debt;

    assign tick    = enable && (interval_cnt == LAST);
    assign debt_nz = (debt != 3'd0);

    // A tick and an issued refresh in the same cycle cancel out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            interval_cnt <= '0;
            debt         <= 3'd0;
            overrun      <= 1'b0;
        end else begin
            if (enable) begin
                interval_cnt <= tick ? '0 : interval_cnt + CW'(1);
            end
            if (tick && !issue) begin
                if (debt == 3'd7) begin
                    overrun <= 1'b1;
                end else begin
                    debt <= debt + 3'd1;
                end
            end else if (issue && !tick && debt_nz) begin
                debt <= debt - 3'd1;
            end
        end
    end

endmodule

// File: rtl/u712_chipram_sched.sv
// Chip RAM SDRAM scheduler: power-up init, periodic auto-refresh and
// fixed-priority arbitration of the single port between Agnus DMA and the CPU.
module u712_chipram_sched #(
    parameter int          INIT_WAIT    = 16000,
    parameter int          CKE_WAIT     = 8,
    parameter int          REF_INTERVAL = 624,
    parameter int          T_RP         = 2,
    parameter int          T_RC         = 6,
    parameter int          T_MRD        = 2,
    parameter logic [10:0] MODE_WORD    = 11'h020
) (
    input  logic        CLK80,
    input  logic        RESETn,
    input  logic        DMA_REQ,
    input  logic        CPU_REQ,
    input  logic        CYCLE_DONE,
    output logic        DMA_GNT,
    output logic        CPU_GNT,
    output logic        CLK_EN,
    output logic        SCHED_CMD_VALID,
    output logic [1:0]  SCHED_CMD,
    output logic [10:0] SCHED_CMA,
    output logic        INIT_DONE,
    output logic        REF_OVERRUN
);

    import u712_pkg::*;

    // Command-to-command spacing N means N-1 cycles in the wait state
    // that follows the one-cycle strobe.
    localparam logic [15:0] PWR_LAST  = 16'(INIT_WAIT - 1);
    localparam logic [15:0] CKE_LAST  = 16'(CKE_WAIT - 1);
    localparam logic [15:0] TRP_LAST  = 16'(T_RP - 2);
    localparam logic [15:0] TRC_LAST  = 16'(T_RC - 2);
    localparam logic [15:0] TMRD_LAST = 16'(T_MRD - 2);

    sched_state_t state;
    sched_state_t state_next;
    logic [15:0]  wait_cnt;
    logic         init_done;
    logic         cmd_valid;
    logic [1:0]   cmd;
    logic [10:0]  cma;
    logic         ref_issue;
    logic         ref_tick;
    logic         debt_nz;
    logic         overrun;

    u712_refresh_timer #(
        .REF_INTERVAL(REF_INTERVAL)
    ) refresh_timer (
        .clk     (CLK80),
        .rst_n   (RESETn),
        .enable  (init_done),
        .issue   (ref_issue),
        .tick    (ref_tick),
        .debt_nz (debt_nz),
        .overrun (overrun)
    );

    // The wait counter restarts on every state change
    always_ff @(posedge CLK80 or negedge RESETn) begin
        if (!RESETn) begin
            state     <= ST_WAIT_PWR;
            wait_cnt  <= 16'd0;
            init_done <= 1'b0;
        end else begin
            state    <= state_next;
            wait_cnt <= (state_next != state) ? 16'd0 : wait_cnt + 16'd1;
            if (state_next == ST_IDLE) begin
                init_done <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        cmd_valid  = 1'b0;
        cmd        = CMD_NOP;
        cma        = 11'd0;
        ref_issue  = 1'b0;
        case (state)
            ST_WAIT_PWR: if (wait_cnt == PWR_LAST) state_next = ST_WAIT_CKE;
            ST_WAIT_CKE: if (wait_cnt == CKE_LAST) state_next = ST_PRE;
            ST_PRE: begin
                cmd_valid  = 1'b1;
                cmd        = CMD_PRE;
                cma        = CMA_PRECHARGE_ALL;
                state_next = ST_TRP;
            end
            ST_TRP: if (wait_cnt == TRP_LAST) state_next = ST_REF1;
            ST_REF1: begin
                cmd_valid  = 1'b1;
                cmd        = CMD_REF;
                state_next = ST_TRC1;
            end
            ST_TRC1: if (wait_cnt == TRC_LAST) state_next = ST_REF2;
            ST_REF2: begin
                cmd_valid  = 1'b1;
                cmd        = CMD_REF;
                state_next = ST_TRC2;
            end
            ST_TRC2: if (wait_cnt == TRC_LAST) state_next = ST_MRS;
            ST_MRS: begin
                cmd_valid  = 1'b1;
                cmd        = CMD_MRS;
                cma        = MODE_WORD;
                state_next = ST_TMRD;
            end
            ST_TMRD: if (wait_cnt == TMRD_LAST) state_next = ST_IDLE;
            // Agnus slots cannot stall, so DMA beats a pending refresh
            ST_IDLE: begin
                if (DMA_REQ) begin
                    state_next = ST_DMA_BUSY;
                end else if (debt_nz) begin
                    cmd_valid  = 1'b1;
                    cmd        = CMD_REF;
                    ref_issue  = 1'b1;
                    state_next = ST_RWAIT;
                end else if (CPU_REQ) begin
                    state_next = ST_CPU_BUSY;
                end
            end
            ST_RWAIT:    if (wait_cnt == TRC_LAST) state_next = ST_IDLE;
            ST_DMA_BUSY: if (CYCLE_DONE || !DMA_REQ) state_next = ST_IDLE;
            ST_CPU_BUSY: if (CYCLE_DONE || !CPU_REQ) state_next = ST_IDLE;
            default:     state_next = ST_WAIT_PWR;
        endcase
    end

    assign DMA_GNT         = (state == ST_DMA_BUSY);
    assign CPU_GNT         = (state == ST_CPU_BUSY);
    assign CLK_EN          = (state != ST_WAIT_PWR);
    assign SCHED_CMD_VALID = cmd_valid;
    assign SCHED_CMD       = cmd;
    assign SCHED_CMA       = cma;
    assign INIT_DONE       = init_done;
    assign REF_OVERRUN     = overrun;

endmodule

// File: tb/tb_u712_chipram_sched.sv
// Self-checking bench for u712_chipram_sched: a schedule-level model checked
// every cycle, plus hand-computed checkpoints for init, arbitration and refresh.
module tb_u712_chipram_sched;

    localparam int W    = 20;
    localparam int K    = 4;
    localparam int RI   = 50;
    localparam int TRP  = 2;
    localparam int TRC  = 6;
    localparam int TMRD = 2;
    localparam int P    = W + K;
    localparam int R1   = P + TRP;
    localparam int R2   = R1 + TRC;
    localparam int MR   = R2 + TRC;
    localparam int D    = MR + TMRD;

    logic        CLK80 = 1'b0;
    logic        RESETn = 1'b1;
    logic        DMA_REQ = 1'b0;
    logic        CPU_REQ = 1'b0;
    logic        CYCLE_DONE = 1'b0;
    logic        DMA_GNT;
    logic        CPU_GNT;
    logic        CLK_EN;
    logic        SCHED_CMD_VALID;
    logic [1:0]  SCHED_CMD;
    logic [10:0] SCHED_CMA;
    logic        INIT_DONE;
    logic        REF_OVERRUN;

    int errors = 0;
    int checks = 0;

    u712_chipram_sched #(
        .INIT_WAIT    (W),
        .CKE_WAIT     (K),
        .REF_INTERVAL (RI),
        .T_RP         (TRP),
        .T_RC         (TRC),
        .T_MRD        (TMRD),
        .MODE_WORD    (11'h020)
    ) dut (
        .CLK80           (CLK80),
        .RESETn          (RESETn),
        .DMA_REQ         (DMA_REQ),
        .CPU_REQ         (CPU_REQ),
        .CYCLE_DONE      (CYCLE_DONE),
        .DMA_GNT         (DMA_GNT),
        .CPU_GNT         (CPU_GNT),
        .CLK_EN          (CLK_EN),
        .SCHED_CMD_VALID (SCHED_CMD_VALID),
        .SCHED_CMD       (SCHED_CMD),
        .SCHED_CMA       (SCHED_CMA),
        .INIT_DONE       (INIT_DONE),
        .REF_OVERRUN     (REF_OVERRUN)
    );

    always #5 CLK80 = ~CLK80;

    function automatic logic [18:0] packOut(input logic dma, input logic cpu, input logic cke,
                                            input logic valid, input logic [1:0] cmd,
                                            input logic [10:0] cma, input logic done,
                                            input logic over);
        return {dma, cpu, cke, valid, cmd, cma, done, over};
    endfunction

    function automatic logic [18:0] dutOut();
        return packOut(DMA_GNT, CPU_GNT, CLK_EN, SCHED_CMD_VALID, SCHED_CMD, SCHED_CMA,
                       INIT_DONE, REF_OVERRUN);
    endfunction

    // Model state: cycles since reset release, port owner (0 none, 1 DMA, 2 CPU),
    // cycle from which arbitration resumes after a refresh, refresh debt, overrun flag.
    int m_cyc = 0;
    int m_owner = 0;
    int m_hold = 0;
    int m_debt = 0;
    bit m_over = 1'b0;
    int n_cyc;
    int n_owner;
    int n_hold;
    int n_debt;
    bit n_over;

    always @(negedge CLK80) begin
        logic        e_dma;
        logic        e_cpu;
        logic        e_valid;
        logic [1:0]  e_cmd;
        logic [10:0] e_cma;
        logic [18:0] expv;
        bit          tick;
        bit          issue;
        e_dma = 1'b0; e_cpu = 1'b0; e_valid = 1'b0; e_cmd = 2'b00; e_cma = 11'h000;
        tick = 1'b0; issue = 1'b0;
        n_cyc = m_cyc + 1; n_owner = m_owner; n_hold = m_hold; n_debt = m_debt; n_over = m_over;
        if (RESETn) begin
            if (m_cyc == P) begin
                e_valid = 1'b1; e_cmd = 2'b01; e_cma = 11'h400;
            end else if (m_cyc == R1 || m_cyc == R2) begin
                e_valid = 1'b1; e_cmd = 2'b10;
            end else if (m_cyc == MR) begin
                e_valid = 1'b1; e_cmd = 2'b11; e_cma = 11'h020;
            end
            if (m_cyc >= D) begin
                tick = (((m_cyc - D) % RI) == RI - 1);
                if (m_owner == 1) begin
                    e_dma = 1'b1;
                    if (!DMA_REQ || CYCLE_DONE) n_owner = 0;
                end else if (m_owner == 2) begin
                    e_cpu = 1'b1;
                    if (!CPU_REQ || CYCLE_DONE) n_owner = 0;
                end else if (m_cyc >= m_hold) begin
                    if (DMA_REQ) begin
                        n_owner = 1;
                    end else if (m_debt > 0) begin
                        e_valid = 1'b1; e_cmd = 2'b10; issue = 1'b1;
                        n_hold = m_cyc + TRC;
                    end else if (CPU_REQ) begin
                        n_owner = 2;
                    end
                end
                if (tick && !issue) begin
                    if (m_debt == 7) n_over = 1'b1;
                    else n_debt = m_debt + 1;
                end else if (issue && !tick) begin
                    n_debt = m_debt - 1;
                end
            end
            expv = packOut(e_dma, e_cpu, (m_cyc >= W), e_valid, e_cmd, e_cma, (m_cyc >= D), m_over);
        end else begin
            expv = 19'd0;
        end
        checks++;
        if (dutOut() !== expv) begin
            errors++;
            $display("[TB] FAIL modelCompare cyc=%0d t=%0t actual=%h required=%h",
                     m_cyc, $time, dutOut(), expv);
        end
    end

    always @(posedge CLK80 or negedge RESETn) begin
        if (!RESETn) begin
            m_cyc <= 0; m_owner <= 0; m_hold <= 0; m_debt <= 0; m_over <= 1'b0;
        end else begin
            m_cyc <= n_cyc; m_owner <= n_owner; m_hold <= n_hold;
            m_debt <= n_debt; m_over <= n_over;
        end
    end

    task automatic checkOutput(input string name, input logic [18:0] actual,
                               input logic [18:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s cyc=%0d actual=%h required=%h", name, m_cyc, actual, required);
        end
    endtask

    task automatic gotoCycle(input int n);
        int guard;
        guard = 0;
        while (m_cyc < n && guard < 2000) begin
            @(posedge CLK80);
            #1;
            guard++;
        end
        if (m_cyc != n) begin
            checks++;
            errors++;
            $display("[TB] FAIL gotoCycle actual=%0d required=%0d", m_cyc, n);
        end
    endtask

    task automatic applyStimulus(input int n, input logic dma, input logic cpu, input logic done);
        gotoCycle(n);
        DMA_REQ    = dma;
        CPU_REQ    = cpu;
        CYCLE_DONE = done;
    endtask

    initial begin
        int strobes;
        int last_strobe;
        #1 RESETn = 1'b0;
        repeat (3) @(posedge CLK80);
        #1 checkOutput("resetOutputs", dutOut(), 19'd0);
        CPU_REQ = 1'b1;
        RESETn  = 1'b1;

        // Init sequence with a CPU request that must be ignored
        gotoCycle(19); #1 checkOutput("ckeLowAt19", 19'(CLK_EN), 19'd0);
        gotoCycle(20); #1 checkOutput("ckeHighAt20", 19'(CLK_EN), 19'd1);
        gotoCycle(24); #1 checkOutput("preStrobe", 19'({SCHED_CMD_VALID, SCHED_CMD, SCHED_CMA}), 19'({1'b1, 2'b01, 11'h400}));
        gotoCycle(26); #1 checkOutput("ref1Strobe", 19'({SCHED_CMD_VALID, SCHED_CMD, SCHED_CMA}), 19'({1'b1, 2'b10, 11'h000}));
        gotoCycle(32); #1 checkOutput("ref2Strobe", 19'({SCHED_CMD_VALID, SCHED_CMD, SCHED_CMA}), 19'({1'b1, 2'b10, 11'h000}));
        gotoCycle(38); #1 checkOutput("mrsStrobe", 19'({SCHED_CMD_VALID, SCHED_CMD, SCHED_CMA}), 19'({1'b1, 2'b11, 11'h020}));
        gotoCycle(39); #1 checkOutput("notDoneAt39", 19'({INIT_DONE, CPU_GNT}), 19'b00);
        gotoCycle(40); #1 checkOutput("doneAt40", 19'({INIT_DONE, CPU_GNT}), 19'b10);
        gotoCycle(41); #1 checkOutput("cpuGntAt41", 19'(CPU_GNT), 19'd1);
        applyStimulus(43, 1'b0, 1'b1, 1'b1);
        applyStimulus(44, 1'b0, 1'b0, 1'b0); #1 checkOutput("cpuDoneDrop", 19'(CPU_GNT), 19'd0);

        // Simultaneous DMA and CPU with no refresh owed
        applyStimulus(50, 1'b1, 1'b1, 1'b0);
        gotoCycle(51); #1 checkOutput("dmaWins", 19'({DMA_GNT, CPU_GNT}), 19'b10);
        applyStimulus(55, 1'b1, 1'b1, 1'b1);
        applyStimulus(56, 1'b0, 1'b1, 1'b0); #1 checkOutput("gapCycle", 19'({DMA_GNT, CPU_GNT}), 19'b00);
        gotoCycle(57); #1 checkOutput("cpuAfterDma", 19'({DMA_GNT, CPU_GNT}), 19'b01);
        applyStimulus(60, 1'b0, 1'b1, 1'b1);
        applyStimulus(61, 1'b0, 1'b0, 1'b0);

        // Refresh owed from cycle 90 beats a CPU request raised that cycle
        applyStimulus(90, 1'b0, 1'b1, 1'b0); #1 checkOutput("refreshFirst", 19'({SCHED_CMD_VALID, SCHED_CMD}), 19'b110);
        gotoCycle(96); #1 checkOutput("cpuWaitsTrc", 19'(CPU_GNT), 19'd0);
        gotoCycle(97); #1 checkOutput("cpuAfterRefresh", 19'(CPU_GNT), 19'd1);
        applyStimulus(99, 1'b0, 1'b1, 1'b1);
        applyStimulus(100, 1'b0, 1'b0, 1'b0);

        // DMA hogs the port across eight refresh ticks
        applyStimulus(110, 1'b1, 1'b0, 1'b0);
        gotoCycle(111); #1 checkOutput("dmaHold", 19'(DMA_GNT), 19'd1);
        gotoCycle(489); #1 checkOutput("noOverrunYet", 19'(REF_OVERRUN), 19'd0);
        gotoCycle(490); #1 checkOutput("overrunSet", 19'(REF_OVERRUN), 19'd1);
        applyStimulus(491, 1'b1, 1'b0, 1'b1);
        applyStimulus(492, 1'b0, 1'b0, 1'b0);
        strobes = 0;
        last_strobe = -1;
        for (int c = 492; c <= 535; c++) begin
            gotoCycle(c);
            #1;
            if (SCHED_CMD_VALID === 1'b1) begin
                strobes++;
                last_strobe = c;
            end
        end
        checkOutput("burstCount", 19'(strobes), 19'd7);
        checkOutput("burstLast", 19'(last_strobe), 19'd528);
        checkOutput("overrunSticky", 19'(REF_OVERRUN), 19'd1);

        // CPU abort then a fresh DMA grant
        applyStimulus(550, 1'b0, 1'b1, 1'b0);
        gotoCycle(551); #1 checkOutput("cpuGranted", 19'(CPU_GNT), 19'd1);
        applyStimulus(553, 1'b0, 1'b0, 1'b0);
        gotoCycle(554); #1 checkOutput("cpuAbortDrop", 19'(CPU_GNT), 19'd0);
        applyStimulus(556, 1'b1, 1'b0, 1'b0);
        gotoCycle(557); #1 checkOutput("dmaAfterAbort", 19'(DMA_GNT), 19'd1);
        applyStimulus(559, 1'b1, 1'b0, 1'b1);
        applyStimulus(560, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset during CPU_BUSY and during init
        applyStimulus(565, 1'b0, 1'b1, 1'b0);
        gotoCycle(566); #1 checkOutput("cpuBeforeReset", 19'(CPU_GNT), 19'd1);
        gotoCycle(568);
        #1 RESETn = 1'b0;
        #1 checkOutput("asyncResetBusy", dutOut(), 19'd0);
        repeat (2) @(posedge CLK80);
        #1 RESETn = 1'b1;
        gotoCycle(22); #1 checkOutput("ckeBeforeReset", 19'(CLK_EN), 19'd1);
        RESETn = 1'b0;
        #1 checkOutput("asyncResetInit", dutOut(), 19'd0);
        repeat (2) @(posedge CLK80);
        #1 RESETn  = 1'b1;
        CPU_REQ = 1'b0;
        gotoCycle(19); #1 checkOutput("restartCkeLow", 19'(CLK_EN), 19'd0);
        gotoCycle(20); #1 checkOutput("restartCkeHigh", 19'(CLK_EN), 19'd1);
        gotoCycle(40); #1 checkOutput("restartDone", 19'(INIT_DONE), 19'd1);
        gotoCycle(45);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
